// File: rtl/sdram_line_fetch_arbiter.sv
// Round-robin burst read scheduler for four line-buffer address generators.
// Grants one requester, issues a fixed-length read, counts beats, then clears.
module sdram_line_fetch_arbiter #(
   parameter logic [7:0]  BURST_LEN   = 8'd160,
   parameter logic [22:0] FRAME_WORDS = 23'd384000
) (
   input  logic        iRST,
   input  logic        iCLK_W,
   input  logic [3:0]  iREQ,
   input  logic [91:0] iBASE,
   input  logic        iFRAME_SYNC,
   input  logic        iRD_ACK,
   input  logic        iRD_VALID,
   output logic        oRD_REQ,
   output logic [22:0] oRD_ADDR,
   output logic [7:0]  oRD_LEN,
   output logic [1:0]  oRD_SEL,
   output logic [3:0]  oCLR,
   output logic        oBUSY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
      S_DONE
   } state_t;

   state_t      st_q;
   logic [22:0] off_q [4];
   logic [1:0]  rr_q;
   logic [1:0]  g_q;
   logic [7:0]  beat_q;
   logic        sync_pend_q;

   logic [22:0] base_a [4];
   logic [1:0]  idx_d;
   logic [1:0]  pick_d;
   logic [22:0] off_sel_d;
   logic [22:0] addr_d;
   logic [23:0] off_sum_d;
   logic [22:0] off_next_d;

   assign oRD_LEN = BURST_LEN;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         base_a[k] = iBASE[23*k +: 23];
      end
   end

   // Descending scan so the nearest set bit above rr wins.
   always_comb begin
      pick_d = rr_q;
      idx_d  = rr_q;
      for (int k = 3; k >= 0; k--) begin
         idx_d = rr_q + k[1:0];
         if (iREQ[idx_d]) begin
            pick_d = idx_d;
         end
      end
   end

   always_comb begin
      off_sel_d = iFRAME_SYNC ? 23'd0 : off_q[pick_d];
      addr_d    = base_a[pick_d] + off_sel_d;
      off_sum_d = {1'b0, off_q[g_q]} + {16'd0, BURST_LEN};
      off_next_d = (off_sum_d == {1'b0, FRAME_WORDS}) ?
                   23'd0 : off_sum_d[22:0];
   end

   always_ff @(posedge iCLK_W or posedge iRST) begin
      if (iRST) begin
         st_q        <= S_IDLE;
         rr_q        <= 2'd0;
         g_q         <= 2'd0;
         beat_q      <= 8'd0;
         sync_pend_q <= 1'b0;
         oRD_REQ     <= 1'b0;
         oRD_ADDR    <= 23'd0;
         oRD_SEL     <= 2'd0;
         oCLR        <= 4'd0;
         oBUSY       <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            off_q[k] <= 23'd0;
         end
      end else begin
         unique case (st_q)
            S_IDLE: begin
               if (iFRAME_SYNC) begin
                  for (int k = 0; k < 4; k++) begin
                     off_q[k] <= 23'd0;
                  end
               end
               if (|iREQ) begin
                  g_q      <= pick_d;
                  oRD_SEL  <= pick_d;
                  oRD_ADDR <= addr_d;
                  oRD_REQ  <= 1'b1;
                  oBUSY    <= 1'b1;
                  st_q     <= S_CMD;
               end
            end
            S_CMD: begin
               if (iFRAME_SYNC) begin
                  sync_pend_q <= 1'b1;
               end
               if (iRD_ACK) begin
                  oRD_REQ <= 1'b0;
                  beat_q  <= 8'd0;
                  st_q    <= S_DATA;
               end
            end
            S_DATA: begin
               if (iFRAME_SYNC) begin
                  sync_pend_q <= 1'b1;
               end
               if (iRD_VALID) begin
                  beat_q <= beat_q + 8'd1;
                  if (beat_q == BURST_LEN - 8'd1) begin
                     oCLR[g_q] <= 1'b1;
                     st_q      <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               oCLR        <= 4'd0;
               rr_q        <= g_q + 2'd1;
               sync_pend_q <= 1'b0;
               oBUSY       <= 1'b0;
               st_q        <= S_IDLE;
               // A pending frame sync wins over the offset advance.
               if (sync_pend_q || iFRAME_SYNC) begin
                  for (int k = 0; k < 4; k++) begin
                     off_q[k] <= 23'd0;
                  end
               end else begin
                  off_q[g_q] <= off_next_d;
               end
            end
            default: begin
               st_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_line_fetch_arbiter.sv
// Randomised and directed bench for sdram_line_fetch_arbiter with a
// transaction-level reference model checked every cycle.
module tb_sdram_line_fetch_arbiter;

   localparam int BL = 160;
   localparam int FW = 320;

   logic        iRST;
   logic        iCLK_W;
   logic [3:0]  iREQ;
   logic [91:0] iBASE;
   logic        iFRAME_SYNC;
   logic        iRD_ACK;
   logic        iRD_VALID;
   logic        oRD_REQ;
   logic [22:0] oRD_ADDR;
   logic [7:0]  oRD_LEN;
   logic [1:0]  oRD_SEL;
   logic [3:0]  oCLR;
   logic        oBUSY;

   logic [3:0]  raise;
   int          checks;
   int          errors;

   sdram_line_fetch_arbiter #(
      .BURST_LEN  (8'd160),
      .FRAME_WORDS(23'd320)
   ) dut (
      .iRST       (iRST),
      .iCLK_W     (iCLK_W),
      .iREQ       (iREQ),
      .iBASE      (iBASE),
      .iFRAME_SYNC(iFRAME_SYNC),
      .iRD_ACK    (iRD_ACK),
      .iRD_VALID  (iRD_VALID),
      .oRD_REQ    (oRD_REQ),
      .oRD_ADDR   (oRD_ADDR),
      .oRD_LEN    (oRD_LEN),
      .oRD_SEL    (oRD_SEL),
      .oCLR       (oCLR),
      .oBUSY      (oBUSY)
   );

   initial begin
      iCLK_W = 1'b0;
      forever #5 iCLK_W = ~iCLK_W;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference model: a burst is "waiting for ack", then "beats left",
   // then one clear cycle; offsets advance modulo the frame size.
   int   m_off [4];
   int   m_rr;
   int   m_g;
   int   m_left;
   bit   m_busy;
   bit   m_cmd;
   bit   m_pend;
   bit   m_found;
   logic        e_req;
   logic [22:0] e_addr;
   logic [1:0]  e_sel;
   logic [3:0]  e_clr;

   initial begin
      forever begin
         @(posedge iCLK_W or posedge iRST);
         if (iRST) begin
            for (int k = 0; k < 4; k++) m_off[k] = 0;
            m_rr = 0; m_g = 0; m_left = 0;
            m_busy = 0; m_cmd = 0; m_pend = 0;
            e_req = 0; e_addr = '0; e_sel = '0; e_clr = '0;
         end else begin
            e_clr = '0;
            if (!m_busy) begin
               if (iFRAME_SYNC)
                  for (int k = 0; k < 4; k++) m_off[k] = 0;
               if (iREQ != 4'd0) begin
                  m_found = 0;
                  for (int k = 0; k < 4; k++) begin
                     if (!m_found && iREQ[(m_rr + k) % 4]) begin
                        m_found = 1;
                        m_g = (m_rr + k) % 4;
                     end
                  end
                  e_addr = 23'((int'(iBASE[23*m_g +: 23]) + m_off[m_g])
                               & 32'h7FFFFF);
                  e_sel  = 2'(m_g);
                  e_req  = 1'b1;
                  m_busy = 1;
                  m_cmd  = 1;
               end
            end else if (m_cmd) begin
               if (iFRAME_SYNC) m_pend = 1;
               if (iRD_ACK) begin
                  e_req  = 1'b0;
                  m_cmd  = 0;
                  m_left = BL;
               end
            end else if (m_left > 0) begin
               if (iFRAME_SYNC) m_pend = 1;
               if (iRD_VALID) begin
                  m_left--;
                  if (m_left == 0) e_clr[m_g] = 1'b1;
               end
            end else begin
               m_rr = (m_g + 1) % 4;
               m_off[m_g] = (m_off[m_g] + BL) % FW;
               if (m_pend || iFRAME_SYNC)
                  for (int k = 0; k < 4; k++) m_off[k] = 0;
               m_pend = 0;
               m_busy = 0;
            end
         end
      end
   end

   always @(negedge iCLK_W) begin
      if (!iRST) begin
         chk("m_req", 32'(oRD_REQ), 32'(e_req));
         chk("m_addr", 32'(oRD_ADDR), 32'(e_addr));
         chk("m_sel", 32'(oRD_SEL), 32'(e_sel));
         chk("m_clr", 32'(oCLR), 32'(e_clr));
         chk("m_busy", 32'(oBUSY), 32'(m_busy));
         chk("m_len", 32'(oRD_LEN), 32'(BL));
      end
   end

   // Requesters register oCLR; a raise in the same cycle wins.
   task automatic tick();
      @(negedge iCLK_W);
      iREQ        = (iREQ & ~oCLR) | raise;
      raise       = '0;
      iRD_ACK     = 1'b0;
      iFRAME_SYNC = 1'b0;
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_req"}, 32'(oRD_REQ), 32'd0);
      chk({tag, "_addr"}, 32'(oRD_ADDR), 32'd0);
      chk({tag, "_sel"}, 32'(oRD_SEL), 32'd0);
      chk({tag, "_clr"}, 32'(oCLR), 32'd0);
      chk({tag, "_busy"}, 32'(oBUSY), 32'd0);
      chk({tag, "_len"}, 32'(oRD_LEN), 32'd160);
   endtask

   task automatic mid_reset(input string tag);
      #2 iRST = 1'b1;
      #1 rst_chk(tag);
      iREQ      = '0;
      raise     = '0;
      iRD_VALID = 1'b0;
      tick();
      tick();
      iRST = 1'b0;
   endtask

   task automatic set_base(input int n, input logic [22:0] v);
      iBASE[23*n +: 23] = v;
   endtask

   task automatic do_burst(input logic [22:0] ea, input logic [1:0] es,
                           input int ack_dly, input int sync_at,
                           input int rst_at);
      int  n;
      int  beats;
      bit  v;
      bit  synced;
      n = 0;
      while (!oRD_REQ && n < 50) begin
         tick();
         n++;
      end
      if (!oRD_REQ) begin
         chk("req_timeout", 32'd0, 32'd1);
         return;
      end
      chk("addr", 32'(oRD_ADDR), 32'(ea));
      chk("sel", 32'(oRD_SEL), 32'(es));
      for (int i = 0; i < ack_dly; i++) begin
         iRD_VALID = i[0];
         tick();
         chk("req_hold", 32'(oRD_REQ), 32'd1);
         chk("addr_hold", 32'(oRD_ADDR), 32'(ea));
      end
      iRD_VALID = 1'b0;
      iRD_ACK   = 1'b1;
      tick();
      chk("req_drop", 32'(oRD_REQ), 32'd0);
      beats  = 0;
      synced = 0;
      while (beats < BL) begin
         v = ($urandom % 4) != 0;
         iRD_VALID = v;
         if (beats == sync_at && !synced) begin
            iFRAME_SYNC = 1'b1;
            synced = 1;
         end
         if (beats == rst_at) begin
            mid_reset("rst_mid");
            return;
         end
         if (v) beats++;
         tick();
         if (beats < BL) chk("clr_early", 32'(oCLR), 32'd0);
      end
      iRD_VALID = 1'b0;
      chk("clr", 32'(oCLR), 32'(4'b0001 << es));
      chk("busy_done", 32'(oBUSY), 32'd1);
      tick();
      chk("clr_once", 32'(oCLR), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      raise = '0;
      iRST = 1'b0;
      iREQ = '0;
      iBASE = '0;
      iFRAME_SYNC = 1'b0;
      iRD_ACK = 1'b0;
      iRD_VALID = 1'b0;
      set_base(0, 23'h001000);
      set_base(1, 23'h004000);
      set_base(2, 23'h002000);
      set_base(3, 23'h7FFF80);
      #3 iRST = 1'b1;
      repeat (3) @(negedge iCLK_W);
      rst_chk("reset");
      iRST = 1'b0;
      tick();

      // Single request, then a stalled command on the next burst.
      raise = 4'b0001;
      do_burst(23'h001000, 2'd0, 3, -1, -1);
      raise = 4'b0001;
      do_burst(23'h0010A0, 2'd0, 20, -1, -1);

      // Reset partway through a burst.
      raise = 4'b0001;
      do_burst(23'h001000, 2'd0, 0, -1, 80);

      // Round-robin from a fresh pointer.
      raise = 4'b1111;
      do_burst(23'h001000, 2'd0, 1, -1, -1);
      raise = 4'b0001;
      do_burst(23'h004000, 2'd1, 0, -1, -1);
      do_burst(23'h002000, 2'd2, 2, -1, -1);
      do_burst(23'h7FFF80, 2'd3, 0, -1, -1);
      do_burst(23'h0010A0, 2'd0, 1, -1, -1);

      // Frame wrap for requester 2 and address wrap for requester 3.
      raise = 4'b0100;
      do_burst(23'h0020A0, 2'd2, 0, -1, -1);
      raise = 4'b0100;
      do_burst(23'h002000, 2'd2, 0, -1, -1);
      raise = 4'b1000;
      do_burst(23'h000020, 2'd3, 0, -1, -1);

      // Frame sync during requester 1's second burst.
      raise = 4'b0010;
      do_burst(23'h0040A0, 2'd1, 0, 50, -1);
      raise = 4'b0001;
      do_burst(23'h001000, 2'd0, 0, -1, -1);
      raise = 4'b0010;
      do_burst(23'h004000, 2'd1, 0, -1, -1);
      raise = 4'b1000;
      do_burst(23'h7FFF80, 2'd3, 0, -1, -1);

      // Frame sync in IDLE coincident with a grant.
      raise = 4'b0001;
      tick();
      iFRAME_SYNC = 1'b1;
      do_burst(23'h001000, 2'd0, 0, -1, -1);

      // Random traffic checked by the model.
      for (int n = 0; n < 4; n++) set_base(n, 23'($urandom));
      for (int i = 0; i < 40000; i++) begin
         if (i == 15000) mid_reset("rst_rand");
         for (int n = 0; n < 4; n++)
            raise[n] = ($urandom % 8) == 0;
         tick();
         iRD_ACK     = oRD_REQ && (($urandom % 3) == 0);
         iRD_VALID   = ($urandom % 4) != 0;
         iFRAME_SYNC = ($urandom % 300) == 0;
      end
      tick();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_line_fetch_arbiter.md
# sdram_line_fetch_arbiter

Round-robin scheduler that shares the SDRAM read port between four line-buffer address generators. Each generator raises a level request when its line buffer has room for another burst. The arbiter grants one requester at a time and issues a fixed-length burst read at that requester's current frame offset. It counts the returned data beats, then pulses the requester's clear line. It sits between the line-buffer address generators (their `oREQ_W`/`iREQ_CLR` pairs) and the SDRAM controller read command port, in the `iCLK_W` domain.

## Interface
- `BURST_LEN`, default `8'd160`: words per burst read, legal range 1..255.
- `FRAME_WORDS`, default `23'd384000`: words per frame per requester. Must be a nonzero multiple of `BURST_LEN`.
- `iRST`, in, 1: reset, asynchronous, active-high.
- `iCLK_W`, in, 1: clock; all logic is in this domain.
- `iREQ`, in, 4: level requests. Bit n comes from generator n and is held until `oCLR[n]`.
- `iBASE`, in, 92: four 23-bit SDRAM base addresses. `[22:0]` is requester 0, …, `[91:69]` is requester 3. Treated as quasi-static.
- `iFRAME_SYNC`, in, 1: one-cycle pulse at frame start; rewinds all offsets.
- `iRD_ACK`, in, 1: SDRAM controller accepted the command.
- `iRD_VALID`, in, 1: one read data beat returned.
- `oRD_REQ`, out, 1: burst read command valid.
- `oRD_ADDR`, out, 23: burst start address.
- `oRD_LEN`, out, 8: burst length; constant `BURST_LEN`.
- `oRD_SEL`, out, 2: index of the granted requester, which routes data beats to its line buffer.
- `oCLR`, out, 4: one-cycle clear pulse per requester.
- `oBUSY`, out, 1: high in any state other than IDLE.

## Operation
- **State per requester:** a 23-bit offset `off[n]`.
- **Global state:**
  - round-robin pointer `rr` (2 bits);
  - grant register `g` (2 bits);
  - beat counter (8 bits);
  - `sync_pend` flag.
- **FSM states:** IDLE, CMD, DATA, DONE.
- **IDLE:** if `iREQ != 0`, latch `g` as the first set bit searching from `rr` upward modulo 4. Load `oRD_ADDR = iBASE[g] + off[g]`, truncated modulo 2^23. Set `oRD_SEL = g` and go to CMD.
- **CMD:** `oRD_REQ = 1` and `oRD_ADDR` are held stable until `iRD_ACK` is sampled high. On that edge, `oRD_REQ` goes to 0, the beat counter goes to 0, and the FSM goes to DATA.
- **DATA:** each `iRD_VALID` increments the beat counter. When the `BURST_LEN`-th beat is sampled, go to DONE. `iRD_VALID` outside DATA is ignored.
- **DONE (one cycle):**
  - `oCLR[g] = 1`;
  - `rr = g + 1`, modulo 4;
  - if `off[g] + BURST_LEN == FRAME_WORDS` then `off[g] = 0`, else `off[g] += BURST_LEN`;
  - go to IDLE.
- **Frame sync while busy:** `iFRAME_SYNC` outside IDLE sets `sync_pend`. In DONE, if `sync_pend` is set, all four offsets become 0 (this overrides the increment) and `sync_pend` clears.
- **Frame sync in IDLE:** `iFRAME_SYNC` in IDLE zeroes the offsets immediately. If a grant is taken in the same cycle, the command uses offset 0.
- **Requester contract:** requesters register `oCLR` in `iCLK_W`, so `iREQ[g]` is low in the cycle after DONE. A set and a clear in the same cycle resolve to set, so the request is re-served.
- **Unrequested clears:** requester bits that are not granted never receive `oCLR`.

## Timing
- **Reset values:**
  - `oRD_REQ = 0`, `oRD_ADDR = 0`, `oRD_SEL = 0`, `oCLR = 0`, `oBUSY = 0`;
  - `oRD_LEN = BURST_LEN` at all times;
  - offsets, `rr`, `g`, beat counter and `sync_pend` all 0;
  - FSM in IDLE.
- **Request to command:** `oRD_REQ` rises in the cycle after `iREQ` is seen in IDLE (registered).
- **Minimum burst turnaround:** 1 (IDLE) + 1 (CMD, `iRD_ACK` immediate) + `BURST_LEN` (DATA) + 1 (DONE) cycles.
- **Back-to-back bursts:** IDLE may take a new grant in the cycle directly after DONE.
- **First data beat:** the SDRAM controller returns the first `iRD_VALID` no earlier than the cycle after `iRD_ACK`.
- **Reset mid-burst:** `iRST` abandons the burst; nothing is replayed. The SDRAM controller shares the same reset.
- **Address wrap:** a `base + offset` overflow past 2^23 wraps silently.

## Test plan
- **Single request:** `iBASE[0] = 0x1000`, `iREQ = 0001`, `iRD_ACK` after 3 cycles, 160 beats → `oRD_ADDR = 0x1000` and `oRD_SEL = 0`. `oCLR = 0001` exactly once, in the cycle after beat 160. The next burst from requester 0 is at `0x10A0`.
- **Round-robin:** `iREQ = 1111` held and re-raised after each clear → grant order 0, 1, 2, 3, 0. No `oCLR` to a non-granted bit.
- **Frame wrap:** `FRAME_WORDS = 320`, `BURST_LEN = 160`, requester 2 with base `0x2000` → addresses `0x2000`, `0x20A0`, `0x2000`.
- **Frame sync mid-DATA:** pulse `iFRAME_SYNC` at beat 50 of requester 1's second burst → that burst completes at its old address. Afterwards every requester restarts at its base.
- **Stalled command:** hold `iRD_ACK = 0` for 20 cycles → `oRD_REQ` and `oRD_ADDR` stay stable and `iRD_VALID` pulses are ignored. The burst completes normally after the ack.
- **Async reset mid-burst:** assert `iRST` at beat 80 → all outputs take their reset values immediately. After release the first grant goes to requester 0 at its base address.
